// File: rtl/cla_pkg.sv
// Shared types and look-ahead helpers for the two-level carry-look-ahead adder.
// The same 4-input look-ahead serves both the bit tier and the section tier.
package cla_pkg;

   localparam int GROUP_W        = 4;
   localparam int SECTION_GROUPS = 4;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   typedef struct packed {
      logic [3:1] c;
      gp_t        grp;
   } la_t;

   function automatic logic [3:1] carries4(input gp_t [3:0] gp, input logic cin);
      logic [3:1] c;
      c[1] = gp[0].g | (gp[0].p & cin);
      c[2] = gp[1].g | (gp[1].p & gp[0].g) | (gp[1].p & gp[0].p & cin);
      c[3] = gp[2].g | (gp[2].p & gp[1].g) | (gp[2].p & gp[1].p & gp[0].g)
           | (gp[2].p & gp[1].p & gp[0].p & cin);
      return c;
   endfunction

   function automatic gp_t group_gp(input gp_t [3:0] gp);
      gp_t r;
      r.g = gp[3].g | (gp[3].p & gp[2].g) | (gp[3].p & gp[2].p & gp[1].g)
          | (gp[3].p & gp[2].p & gp[1].p & gp[0].g);
      r.p = gp[3].p & gp[2].p & gp[1].p & gp[0].p;
      return r;
   endfunction

   function automatic la_t lookahead4(input gp_t [3:0] gp, input logic cin);
      la_t r;
      r.c   = carries4(gp, cin);
      r.grp = group_gp(gp);
      return r;
   endfunction

endpackage

// File: rtl/cla_4bit_block.sv
// 4-bit look-ahead group: sum bits from an incoming group carry, plus group G/P.
// G/P are formed without the carry-in so they never sit behind the carry path.
module cla_4bit_block
   import cla_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       G,
   output logic       P
);

   gp_t  [3:0] gp;
   logic [3:0] p_bits;
   logic [3:1] c_int;
   gp_t        grp;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         gp[i].g = a[i] & b[i];
         gp[i].p = a[i] ^ b[i];
      end
   end

   assign p_bits = a ^ b;
   assign c_int  = carries4(gp, cin);
   assign grp    = group_gp(gp);

   assign sum = p_bits ^ {c_int, cin};
   assign G   = grp.g;
   assign P   = grp.p;

endmodule

// File: rtl/carry_look_ahead_adder.sv
// Two-level carry-look-ahead adder with a registered {cout, sum} stage.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module carry_look_ahead_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NG = WIDTH / GROUP_W;
   localparam int NS = NG / SECTION_GROUPS;

   logic [NG-1:0]    grp_g;
   logic [NG-1:0]    grp_p;
   logic [NG-1:0]    grp_c;
   logic [NS-1:0]    sec_g;
   logic [NS-1:0]    sec_p;
   logic [NS:0]      sec_c;
   logic [WIDTH-1:0] sum_d;

   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      cla_4bit_block u_blk (
         .a   (a[GROUP_W*gi +: GROUP_W]),
         .b   (b[GROUP_W*gi +: GROUP_W]),
         .cin (grp_c[gi]),
         .sum (sum_d[GROUP_W*gi +: GROUP_W]),
         .G   (grp_g[gi]),
         .P   (grp_p[gi])
      );
   end

   for (genvar si = 0; si < NS; si++) begin : g_sec
      gp_t  [3:0] sgp;
      gp_t        sgrp;
      logic [3:1] sc;

      always_comb begin
         for (int j = 0; j < SECTION_GROUPS; j++) begin
            sgp[j].g = grp_g[SECTION_GROUPS*si + j];
            sgp[j].p = grp_p[SECTION_GROUPS*si + j];
         end
      end

      assign sc    = carries4(sgp, sec_c[si]);
      assign sgrp  = group_gp(sgp);
      assign sec_g[si] = sgrp.g;
      assign sec_p[si] = sgrp.p;

      assign grp_c[SECTION_GROUPS*si]          = sec_c[si];
      assign grp_c[SECTION_GROUPS*si+1 +: 3]   = sc;
   end

   // Flat sum-of-products over section G*/P*; no carry chains between sections.
   always_comb begin
      logic term;
      logic acc;
      term  = 1'b0;
      acc   = 1'b0;
      sec_c = '0;
      sec_c[0] = cin;
      for (int k = 1; k <= NS; k++) begin
         term = cin;
         for (int m = 0; m < k; m++) term = term & sec_p[m];
         acc = term;
         for (int j = 0; j < k; j++) begin
            term = sec_g[j];
            for (int m = j + 1; m < k; m++) term = term & sec_p[m];
            acc = acc | term;
         end
         sec_c[k] = acc;
      end
   end

`ifdef CLA_OVF_EN
   logic c_msb;
   assign c_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ sum_d[WIDTH-1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
`ifdef CLA_OVF_EN
         ovf  <= 1'b0;
`endif
      end else begin
         sum  <= sum_d;
         cout <= sec_c[NS];
`ifdef CLA_OVF_EN
         ovf  <= c_msb ^ sec_c[NS];
`endif
      end
   end

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Self-checking bench for carry_look_ahead_adder: directed corner cases, then
// back-to-back random adds with asynchronous reset pulses, against an arithmetic model.
module tb_carry_look_ahead_adder;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [W-1:0] sum;
   logic         cout;
`ifdef CLA_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   carry_look_ahead_adder #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
`ifdef CLA_OVF_EN
      ,
      .ovf  (ovf)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic ci);
      logic [W:0] s;
      s = ref_add(x, y, ci);
      return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
   endfunction

   task automatic check_out(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci);
      logic [W:0] exp;
      exp = ref_add(x, y, ci);
      checks++;
      assert ({cout, sum} === exp)
      else begin
         errors++;
         $error("FAIL %s observed cout,sum=%h expected %h", tag, {cout, sum}, exp);
      end
`ifdef CLA_OVF_EN
      checks++;
      assert (ovf === ref_ovf(x, y, ci))
      else begin
         errors++;
         $error("FAIL %s_ovf observed %b expected %b", tag, ovf, ref_ovf(x, y, ci));
      end
`endif
   endtask

   task automatic check_zero(input string tag);
      checks++;
      assert ({cout, sum} === {1'b0, {W{1'b0}}})
      else begin
         errors++;
         $error("FAIL %s observed cout,sum=%h expected 0", tag, {cout, sum});
      end
`ifdef CLA_OVF_EN
      checks++;
      assert (ovf === 1'b0)
      else begin
         errors++;
         $error("FAIL %s_ovf observed %b expected 0", tag, ovf);
      end
`endif
   endtask

   task automatic step(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci);
      @(negedge clk);
      a   = x;
      b   = y;
      cin = ci;
      @(posedge clk);
      #1;
      check_out(tag, x, y, ci);
   endtask

   initial begin
      rst = 1'b1;
      a   = 32'hDEAD_BEEF;
      b   = 32'h1234_5678;
      cin = 1'b1;
      #2;
      check_zero("reset_async");
      repeat (3) begin
         @(negedge clk);
         a   = $urandom();
         b   = $urandom();
         cin = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         check_zero("reset_hold");
      end
      @(negedge clk);
      rst = 1'b0;

      step("basic",        32'd10,         32'd20,         1'b0);
      step("carry_in",     32'd9,          32'd11,         1'b1);
      step("long_chain",   32'h0FFF_FFFF,  32'h0000_0001,  1'b0);
      step("full_cout",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1);
      step("full_prop",    32'hFFFF_FFFF,  32'h0000_0000,  1'b1);
      step("signed_ovf",   32'h7FFF_FFFF,  32'h0000_0001,  1'b0);
      step("neg_ovf",      32'h8000_0000,  32'h8000_0000,  1'b0);
      step("sec_boundary", 32'h0000_FFFF,  32'h0000_0000,  1'b1);
      step("zero",         32'h0000_0000,  32'h0000_0000,  1'b0);
      step("alt_bits",     32'hAAAA_AAAA,  32'h5555_5555,  1'b1);

      // Preload a known nonzero result so the async drop is observable.
      step("pre_reset",    32'h1234_5678,  32'h1111_1111,  1'b0);
      #1 rst = 1'b1;
      #1 check_zero("midcycle_reset");
      #1 rst = 1'b0;
      step("post_reset",   32'h0000_0003,  32'h0000_0004,  1'b1);

      for (int i = 0; i < 2000; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rc;
         ra = $urandom();
         rb = $urandom();
         rc = 1'($urandom_range(0, 1));
         if (i % 8 == 3) rb = ~ra;
         step("random", ra, rb, rc);
         if (i % 250 == 100) begin
            #2 rst = 1'b1;
            #1 check_zero("random_reset");
            #1 rst = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
